// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// funct3 access codes and lane-selection helpers.
package lsu_pkg;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

   // Bit offset of the byte lane selected by addr[1:0].
   function automatic logic [4:0] lane_shift(input logic [1:0] lane);
      return {lane, 3'b000};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
import lsu_pkg::*;

module lsu_align (
   input  logic [31:0] i_word,
   input  logic [31:0] i_old,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_lane,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_ld,
   output logic [31:0] o_st
);

   logic [4:0]  w_shift;
   logic [31:0] w_sh;
   logic [31:0] w_mask;

   always_comb begin
      w_shift = lane_shift(i_lane);
      w_sh    = i_word >> w_shift;
      case (i_funct3)
         F3_B:    o_ld = {{24{w_sh[7]}}, w_sh[7:0]};
         F3_BU:   o_ld = {24'b0, w_sh[7:0]};
         F3_H:    o_ld = {{16{w_sh[15]}}, w_sh[15:0]};
         F3_HU:   o_ld = {16'b0, w_sh[15:0]};
         default: o_ld = w_sh;  // word accesses are aligned, so no shift
      endcase
      case (i_funct3[1:0])
         2'b00:   w_mask = BYTE_MASK << w_shift;
         2'b01:   w_mask = HALF_MASK << w_shift;
         default: w_mask = '1;
      endcase
      o_st = (i_old & ~w_mask) | ((i_wdata << w_shift) & w_mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store initiator onto a word-addressed memory.
// Optional saturating fault counter enabled by defining LSU_FAULT_CNT_EN.
import lsu_pkg::*;

module load_store_unit #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [15:0]       fault_count
);

   lsu_state_e        r_state;
   logic              r_we;
   logic [2:0]        r_f3;
   logic [ADDR_W+1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_fault;
   logic              r_rsp_valid;
   logic [31:0]       r_rsp_rdata;
   logic              r_mem_read;
   logic              r_mem_write;
   logic [31:0]       r_mem_wdata;

   logic              w_legal, w_mis, w_oor, w_fault;
   logic [31:0]       w_ld, w_st;

   always_comb begin
      if (req_we)
         w_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
      else
         w_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                   (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
      w_mis   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      w_oor   = |req_addr[31:ADDR_W+2];
      w_fault = !w_legal || w_mis || w_oor;
   end

   lsu_align u_align (
      .i_word   (mem_rdata),
      .i_old    (mem_rdata),
      .i_wdata  (r_wdata),
      .i_lane   (r_addr[1:0]),
      .i_funct3 (r_f3),
      .o_ld     (w_ld),
      .o_st     (w_st)
   );

   // Memory strobes are registered alongside the state so they never see req_*.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_f3        <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_fault     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_we        <= req_we;
               r_f3        <= req_funct3;
               r_addr      <= req_addr[ADDR_W+1:0];
               r_wdata     <= req_wdata;
               r_fault     <= w_fault;
               r_rsp_rdata <= '0;
               if (w_fault) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
               end else if (req_we && (req_funct3 == F3_W)) begin
                  r_state     <= S_WRITE;
                  r_mem_write <= 1'b1;
                  r_mem_wdata <= req_wdata;
               end else begin
                  r_state    <= S_READ;
                  r_mem_read <= 1'b1;
               end
            end
            S_READ: if (r_we) begin
               r_state     <= S_WRITE;
               r_mem_write <= 1'b1;
               r_mem_wdata <= w_st;
            end else begin
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= w_ld;
            end
            S_WRITE: begin
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_fault <= 1'b0;
            end
         endcase
      end
   end

`ifdef LSU_FAULT_CNT_EN
   logic [15:0] r_fault_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_fault_cnt <= '0;
      else if ((r_state == S_RESP) && r_fault && (r_fault_cnt != 16'hFFFF))
         r_fault_cnt <= r_fault_cnt + 16'd1;
   end

   assign fault_count = r_fault_cnt;
`else
   assign fault_count = '0;
`endif

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_fault = r_fault;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_addr  = r_addr[ADDR_W+1:2];
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

   localparam int ADDR_W = 6;
`ifdef LSU_FAULT_CNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]        req_funct3 = '0;
   logic [31:0]       req_addr = '0, req_wdata = '0;
   logic              req_ready, rsp_valid, rsp_fault, mem_read, mem_write;
   logic [31:0]       rsp_rdata, mem_wdata, mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       fault_count;

   logic [31:0] mem [64];
   int rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0, both_cnt = 0;
   int n_vec = 0, n_err = 0, n_fault = 0;

   load_store_unit #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (mem_read && mem_write) both_cnt++;
   end

   typedef struct {
      bit pre_en; logic [31:0] pre_val;
      bit we; logic [2:0] f3; logic [31:0] addr, wdata;
      logic [31:0] exp_rdata; bit exp_fault; int exp_lat, exp_rd, exp_wr;
      bit chk_en; int chk_idx; logic [31:0] chk_val;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(bit pe, logic [31:0] pv, bit we, logic [2:0] f3,
                               logic [31:0] a, logic [31:0] wd, logic [31:0] er, bit ef,
                               int el, int erd, int ewr, bit ce, int ci, logic [31:0] cv);
      vec_t v;
      v.pre_en = pe; v.pre_val = pv; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el; v.exp_rd = erd; v.exp_wr = ewr;
      v.chk_en = ce; v.chk_idx = ci; v.chk_val = cv;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int rd0, wr0, lat;
      if (v.pre_en) mem[17] = v.pre_val;
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk($sformatf("v%0d_ready_drop", i), req_ready, 0);
      lat = 1;
      while (!rsp_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
      chk($sformatf("v%0d_rdata", i), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d_fault", i), rsp_fault, v.exp_fault);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_single", i), rsp_valid, 0);
      chk($sformatf("v%0d_ready_back", i), req_ready, 1);
      chk($sformatf("v%0d_reads", i), rd_cnt - rd0, v.exp_rd);
      chk($sformatf("v%0d_writes", i), wr_cnt - wr0, v.exp_wr);
      if (v.chk_en) chk($sformatf("v%0d_mem", i), mem[v.chk_idx], v.chk_val);
      if (v.exp_fault) n_fault++;
      chk($sformatf("v%0d_fault_count", i), fault_count, FC_EN ? n_fault : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b2b_val [3];
      int acc_t [3], rsp_t [3];
      int bi, ri, wr0, rs0;
      bit acc;

      for (int k = 0; k < 64; k++) mem[k] = '0;
      //          pe pre           we f3 addr  wdata         rdata         f  lat rd wr ce idx val
      vecs[0]  = mk(0, 0,           1, 2, 'h44, 'hDEADBEEF, 0,            0, 2, 0, 1, 1, 17, 'hDEADBEEF);
      vecs[1]  = mk(0, 0,           0, 2, 'h44, 0,          'hDEADBEEF,   0, 2, 1, 0, 0, 0, 0);
      vecs[2]  = mk(1, 'h000080F0,  0, 0, 'h44, 0,          'hFFFFFFF0,   0, 2, 1, 0, 0, 0, 0);
      vecs[3]  = mk(0, 0,           0, 4, 'h44, 0,          'h000000F0,   0, 2, 1, 0, 0, 0, 0);
      vecs[4]  = mk(0, 0,           0, 1, 'h44, 0,          'hFFFF80F0,   0, 2, 1, 0, 0, 0, 0);
      vecs[5]  = mk(0, 0,           0, 5, 'h46, 0,          'h00000000,   0, 2, 1, 0, 0, 0, 0);
      vecs[6]  = mk(1, 'h11223344,  1, 0, 'h45, 'hAA,       0,            0, 3, 1, 1, 1, 17, 'h1122AA44);
      vecs[7]  = mk(0, 0,           0, 0, 'h47, 0,          'h00000011,   0, 2, 1, 0, 0, 0, 0);
      vecs[8]  = mk(0, 0,           1, 1, 'h46, 'h1234BEEF, 0,            0, 3, 1, 1, 1, 17, 'hBEEFAA44);
      vecs[9]  = mk(0, 0,           0, 1, 'h46, 0,          'hFFFFBEEF,   0, 2, 1, 0, 0, 0, 0);
      vecs[10] = mk(0, 0,           0, 2, 'h42, 0,          0,            1, 1, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 0,           1, 1, 'h101, 'h5555,    0,            1, 1, 0, 0, 0, 0, 0);
      vecs[12] = mk(0, 0,           0, 2, 'h100, 0,         0,            1, 1, 0, 0, 0, 0, 0);
      vecs[13] = mk(0, 0,           0, 3, 'h44, 0,          0,            1, 1, 0, 0, 0, 0, 0);
      vecs[14] = mk(0, 0,           1, 4, 'h44, 'h77,       0,            1, 1, 0, 0, 1, 17, 'hBEEFAA44);
      vecs[15] = mk(0, 0,           1, 2, 'hFC, 'h0BADF00D, 0,            0, 2, 0, 1, 1, 63, 'h0BADF00D);
      vecs[16] = mk(0, 0,           0, 2, 'hFC, 0,          'h0BADF00D,   0, 2, 1, 0, 0, 0, 0);
      vecs[17] = mk(0, 0,           1, 0, 'hFF, 'h12345677, 0,            0, 3, 1, 1, 1, 63, 'h77ADF00D);
      vecs[18] = mk(0, 0,           0, 4, 'hFF, 0,          'h00000077,   0, 2, 1, 0, 0, 0, 0);

      // Reset values while rst_n is held low.
      #12;
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_fault", rsp_fault, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_fault_count", fault_count, 0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

      // Back-to-back loads with req_valid held high.
      b2b_val[0] = 'hA0A0A0A0; b2b_val[1] = 'h0B0B0B0B; b2b_val[2] = 'hC0C0C0C0;
      mem[10] = b2b_val[0]; mem[11] = b2b_val[1]; mem[12] = b2b_val[2];
      bi = 0; ri = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h28;
      for (int c = 0; c < 20 && ri < 3; c++) begin
         if (rsp_valid) begin
            chk($sformatf("b2b_rdata%0d", ri), rsp_rdata, b2b_val[ri]);
            rsp_t[ri] = c;
            ri++;
         end
         acc = req_ready && req_valid;
         @(posedge clk); #1;
         if (acc) begin
            acc_t[bi] = c;
            bi++;
            if (bi < 3) req_addr = 32'h28 + 32'(bi * 4);
            else req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_rsp_count", ri, 3);
      chk("b2b_acc_count", bi, 3);
      if (ri == 3 && bi == 3) begin
         chk("b2b_first_lat", rsp_t[0] - acc_t[0], 2);
         chk("b2b_acc_gap1", acc_t[1] - acc_t[0], 3);
         chk("b2b_acc_gap2", acc_t[2] - acc_t[1], 3);
         chk("b2b_rsp_gap1", rsp_t[1] - rsp_t[0], 3);
         chk("b2b_rsp_gap2", rsp_t[2] - rsp_t[1], 3);
      end

      // Reset asserted while an SB sits in READ.
      mem[17] = 'h11223344;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h45; req_wdata = 32'hAA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mid_in_read", mem_read, 1);
      wr0 = wr_cnt; rs0 = rsp_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_write_low", mem_write, 0);
      chk("mid_rsp_low", rsp_valid, 0);
      chk("mid_ready_async", req_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_no_write", wr_cnt - wr0, 0);
      chk("mid_no_rsp", rsp_cnt - rs0, 0);
      chk("mid_mem_kept", mem[17], 'h11223344);
      chk("mid_ready_after", req_ready, 1);
      chk("mid_fault_count", fault_count, 0);
      chk("never_rd_and_wr", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store initiator that sits between the core's execute stage and the word-addressed data memory. It accepts one byte-addressed RV32I load or store request at a time, turns it into word-granular memory reads and writes, and returns a formatted response. Supported formats are byte, halfword and word, with sign or zero extension. Sub-word stores use read-modify-write. Misaligned, out-of-range and illegal requests are rejected as faults without touching memory.

## Interface
- ADDR_W, 6: memory word-index width (depth 2^ADDR_W words)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 access type
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- rsp_valid  out  1  single-cycle response strobe
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  request rejected; valid with rsp_valid
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (memory writes on the clk edge)
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  32  word to write
- mem_rdata  in  32  combinational read data from memory
- fault_count  out  16  saturating fault counter (see Configuration)

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- req_ready = 1 only in IDLE. A request is accepted when req_valid and req_ready are both 1 on a rising edge. On acceptance the unit latches we, funct3, addr and wdata.
- Legal load funct3 codes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3 codes: 000 SB, 001 SH, 010 SW.
- Any other funct3 is a fault.
- Misalignment is a fault: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
- Out-of-range is a fault: any nonzero addr[31:ADDR_W+2].
- IDLE→RESP on a faulting request, with no memory access.
- IDLE→READ on a load or SB/SH.
- IDLE→WRITE on SW.
- READ: mem_read=1 and mem_addr=addr[ADDR_W+1:2].
  - Load: extract the lane selected by addr[1:0], sign- or zero-extend it into the response register, then →RESP.
  - SB/SH: merge the byte or halfword into the old word, keeping all other bytes, then →WRITE.
- WRITE: mem_write=1, mem_wdata = merged word (SB/SH) or wdata (SW); →RESP.
- RESP: rsp_valid=1 for exactly one cycle, then →IDLE. There is no response backpressure.
- mem_read, mem_write, mem_addr and mem_wdata come from state and latched registers only. There is no combinational path from req_* to mem_*.
- mem_read and mem_write are never both 1.

## Timing
- Reset values:
  - state IDLE, req_ready=1;
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0;
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0;
  - fault_count=0.
- Accept on edge N. rsp_valid is high in the cycle after:
  - fault: edge N+1 (1 cycle);
  - load or SW: edge N+2;
  - SB/SH: edge N+3.
- req_ready drops in the cycle after acceptance and returns in the cycle after RESP. Back-to-back throughput is therefore one request per 2, 3 or 4 cycles.
- Reset asserted mid-operation:
  - state returns immediately to IDLE;
  - any pending write is dropped (mem_write forced 0 asynchronously);
  - no response is issued.

## Configuration
- LSU_FAULT_CNT_EN defined: fault_count increments by 1 in each RESP cycle with rsp_fault=1 and saturates at 16'hFFFF.
- LSU_FAULT_CNT_EN undefined: fault_count is tied to 0 and no counter register exists.

## Structure
- Package lsu_pkg holds:
  - the state enum;
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - localparam helpers for lane selection.
- Sub-module lsu_align is combinational and does two jobs:
  - load extract/extend: inputs word, addr[1:0], funct3;
  - store merge: inputs old word, wdata, addr[1:0], funct3.
- load_store_unit owns the FSM, latches, the response register and the optional counter.

## Test plan
- SW addr 0x44, data 0xDEADBEEF; then LW 0x44. Required:
  - mem_write for one cycle at mem_addr 17 with mem_wdata 0xDEADBEEF;
  - rsp_rdata 0xDEADBEEF two cycles after the load is accepted.
- Memory word 17 = 0x000080F0:
  - LB 0x44 → 0xFFFFFFF0;
  - LBU 0x44 → 0x000000F0;
  - LH 0x44 → 0xFFFF80F0;
  - LHU 0x46 → 0x00000000.
- Memory word 17 = 0x11223344; SB 0x45, data 0xAA:
  - READ, then WRITE of 0x1122AA44;
  - rsp_valid on the third edge after acceptance.
- Misaligned and out-of-range requests:
  - LW 0x42 → rsp_fault=1 after one cycle, with no mem_read or mem_write;
  - SH 0x101 (ADDR_W=6) → fault;
  - with LSU_FAULT_CNT_EN defined, fault_count=2.
- Reset mid-operation: rst_n low during the READ state of an SB → no mem_write and no rsp_valid; req_ready=1 after reset is released.
- Back-to-back: req_valid held high with 3 LW requests → each accepted only when req_ready=1, responses in order, one every 3 cycles.
